// File: rtl/ins_fetch_resp_pkg.sv
// Shared constants, FSM encoding and word helpers for the instruction-fetch responder.
package ins_fetch_resp_pkg;

  localparam logic HIGH           = 1'b1;
  localparam logic LOW            = 1'b0;
  localparam int   DEF_INDEX_BITS = 4;
  localparam int   DEF_ADDR_W     = 32;
  localparam int   WORD_BYTES     = 4;

  typedef enum logic [1:0] {
    IFR_IDLE = 2'd0,
    IFR_FILL = 2'd1,
    IFR_DONE = 2'd2
  } ifr_state_e;

  typedef logic [WORD_BYTES-1:0][7:0] ins_word_t;
  typedef logic [2:0]                 byte_cnt_t;

  // Little-endian lane insert: lane i holds the byte read from base+i.
  function automatic ins_word_t put_byte(input ins_word_t w, input logic [1:0] lane,
                                         input logic [7:0] b);
    ins_word_t r;
    r       = w;
    r[lane] = b;
    return r;
  endfunction

endpackage

// File: rtl/ins_fetch_resp_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
module ins_fetch_resp_icache_dm
  import ins_fetch_resp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:2] rd_addr_i,
  output logic              rd_hit_o,
  output logic [31:0]       rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:2] wr_addr_i,
  input  logic [31:0]       wr_data_i
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]      rd_tag, wr_tag;

  assign rd_idx = rd_addr_i[INDEX_BITS+1:2];
  assign rd_tag = rd_addr_i[ADDR_W-1:INDEX_BITS+2];
  assign wr_idx = wr_addr_i[INDEX_BITS+1:2];
  assign wr_tag = wr_addr_i[ADDR_W-1:INDEX_BITS+2];

  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        valid_q         <= '0;
    else if (wr_en_i) valid_q[wr_idx] <= HIGH;
  end

  // Tag/data need no reset: they are never read while the line is invalid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ins_fetch_resp.sv
// Instruction-fetch responder: icache lookup, 4-byte RAM fill on miss, one-cycle flg_get handshake.
module ins_fetch_resp
  import ins_fetch_resp_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rdy_i,
  input  logic              nd_ins_i,
  input  logic [ADDR_W-1:0] pc_fetch_i,
  input  logic              jal_reset_i,
  input  logic              lsu_busy_i,
  input  logic [7:0]        mem_din_i,
  output logic              flg_get_o,
  output logic [31:0]       ins_in_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_a_o
);

  ifr_state_e        state_q, state_d;
  logic [ADDR_W-1:2] base_q;
  byte_cnt_t         issue_cnt_q, recv_cnt_q, issue_idx;
  logic              pend_q, stall_q;
  ins_word_t         word_q, word_fill;
  logic [31:0]       ins_q, hit_data;
  logic [ADDR_W-1:0] pc_base, issue_addr;
  logic              req, hit, hit_take, miss, issue, byte_vld, fill_done;
  logic [1:0]        pc_lsb_unused;

  assign pc_lsb_unused = pc_fetch_i[1:0];
  assign pc_base       = {pc_fetch_i[ADDR_W-1:2], 2'b00};

  ins_fetch_resp_icache_dm #(.INDEX_BITS(INDEX_BITS), .ADDR_W(ADDR_W)) u_icache_dm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_addr_i (pc_fetch_i[ADDR_W-1:2]),
    .rd_hit_o  (hit),
    .rd_data_o (hit_data),
    .wr_en_i   (rdy_i && fill_done),
    .wr_addr_i (base_q),
    .wr_data_i (word_fill)
  );

  assign req      = (state_q == IFR_IDLE) && nd_ins_i && !jal_reset_i;
  assign hit_take = req && hit;
  assign miss     = req && !hit;

  // A byte due in a stalled cycle is lost, so the first cycle after a stall
  // rewinds the issue pointer to the next byte still missing.
  assign issue_idx = stall_q ? recv_cnt_q : issue_cnt_q;
  assign byte_vld  = (state_q == IFR_FILL) && pend_q && !stall_q && !jal_reset_i;
  assign word_fill = put_byte(word_q, recv_cnt_q[1:0], mem_din_i);
  assign fill_done = byte_vld && (recv_cnt_q == 3'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      state_q <= IFR_IDLE;
    else if (rdy_i) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFR_IDLE: if (req) state_d = hit ? IFR_DONE : IFR_FILL;
      IFR_FILL: begin
        if (jal_reset_i)    state_d = IFR_IDLE;
        else if (fill_done) state_d = IFR_DONE;
      end
      IFR_DONE: state_d = IFR_IDLE;
      default:  state_d = IFR_IDLE;
    endcase
  end

  // Byte 0 goes out in the lookup cycle itself so a clean miss returns in cycle 5.
  always_comb begin
    issue      = LOW;
    issue_addr = {base_q, 2'b00} + ADDR_W'(issue_idx);
    case (state_q)
      IFR_IDLE: begin
        issue      = miss && !lsu_busy_i;
        issue_addr = pc_base;
      end
      IFR_FILL: issue = (issue_idx < 3'd4) && !lsu_busy_i && !jal_reset_i;
      default:  issue = LOW;
    endcase
    if (!rdy_i || rst_i) issue = LOW;
    mem_rd_en_o = issue;
    mem_a_o     = issue ? issue_addr : '0;
    flg_get_o   = (state_q == IFR_DONE);
  end

  assign ins_in_o = ins_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pend_q      <= LOW;
      stall_q     <= LOW;
      word_q      <= '0;
      ins_q       <= '0;
    end else begin
      stall_q <= !rdy_i;
      if (rdy_i) begin
        pend_q <= issue;
        case (state_q)
          IFR_IDLE: begin
            if (miss) begin
              base_q      <= pc_fetch_i[ADDR_W-1:2];
              issue_cnt_q <= byte_cnt_t'(issue);
              recv_cnt_q  <= '0;
            end else if (hit_take) begin
              ins_q <= hit_data;
            end
          end
          IFR_FILL: begin
            issue_cnt_q <= issue_idx + byte_cnt_t'(issue);
            if (byte_vld) begin
              word_q     <= word_fill;
              recv_cnt_q <= recv_cnt_q + 3'd1;
            end
            if (fill_done) ins_q <= word_fill;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
